fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage of the MIPS core. Holds the PC, fetches through a req/ready imem port and presents the instruction to the control unit.
//  Computes next PC from control_unit (Branch, BranchNot, Jump, JumpReg) and alu zero.
//  Advances one instruction per retire pulse from the core.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset; first fetch address
// PORTS
//  clk          in   1   clock, all state updates on rising edge
//  reset        in   1   synchronous, active-high reset
//  imem_req     out  1   fetch request, high only in FETCH
//  imem_addr    out  32  fetch address (= pc), stable while imem_req high
//  imem_ready   in   1   imem_rdata valid this cycle; request completes
//  imem_rdata   in   32  instruction word from imem
//  instr        out  32  latched instruction, drives opcode/funct decode
//  instr_valid  out  1   instr is valid and awaiting retire
//  pc           out  32  address of current instruction
//  pc_plus4     out  32  pc + 4 (jal link value)
//  retire       in   1   core finished current instruction; commit next PC
//  branch       in   1   Branch from control_unit
//  branch_not   in   1   BranchNot from control_unit
//  zero         in   1   alu zero flag
//  jump         in   1   Jump (j/jal)
//  jump_reg     in   1   JumpReg (jr)
//  branch_imm   in   32  sign-extended 16-bit immediate
//  jr_target    in   32  rs register value for jr
//  fault        out  1   misaligned next-PC fault (see CONFIGURATION)
// BEHAVIOUR
//  Reset, sync active-high: state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, fault=0. imem_req=0, as a decode of state.
//  FSM: IDLE -> FETCH next cycle, unconditionally.
//  FETCH: imem_req=1, imem_addr=pc. When imem_ready=1: instr<=imem_rdata and go to HOLD. Otherwise stay; wait states are unbounded.
//  HOLD: instr_valid=1. On retire=1: pc<=next_pc and go to FETCH.
//  HALT (macro only): all outputs frozen; exit only via reset.
//  Latency: accept at edge N -> instr_valid high from cycle N+1. Zero-wait memory gives 2 cycles per instruction.
//  next_pc priority (evaluated combinationally in HOLD):
//    jump_reg -> jr_target
//    jump     -> {pc_plus4[31:28], instr[25:0], 2'b00}
//    taken    -> pc_plus4 + (branch_imm << 2)
//    else     -> pc_plus4
//  taken = branch & (zero ^ branch_not). Beq takes when zero=1; bne takes when zero=0.
//  All arithmetic is 32-bit modulo 2^32. 0xFFFF_FFFC + 4 wraps to 0.
//  retire outside HOLD is ignored. imem_ready outside FETCH is ignored.
//  Control inputs are sampled only on the retire edge.
//  Reset wins over a simultaneous retire or imem_ready. Reset mid-fetch abandons the request (imem_req low next cycle).
//  pc, pc_plus4 and instr stay stable throughout HOLD.
// CONFIGURATION
//  Macro FETCH_MISALIGN_TRAP_EN, for the case next_pc[1:0]!=0 at retire:
//    Defined: pc is not updated, fault<=1 (sticky), state -> HALT, imem_req stays 0 until reset.
//    Undefined: next_pc[1:0] is forced to 2'b00 and fetch continues. fault is tied to 0.
// TESTING
//  T1 reset: RESET_PC=0x0040_0000, reset high 2 cycles -> pc=0x0040_0000, instr_valid=0, imem_req=0. One IDLE cycle, then imem_req=1, imem_addr=0x0040_0000.
//  T2 sequential, zero-wait: imem_ready=1, retire on every instr_valid -> addrs 0x400000, 0x400004, 0x400008; instr_valid 1 cycle after each accept.
//  T3 wait states: imem_ready low 3 cycles -> imem_addr held, instr_valid=0. imem_ready=1 -> instr_valid next cycle, instr=imem_rdata.
//  T4 branch: pc=0x100, branch=1, zero=1, imm=0xFFFF_FFFE -> next 0xFC. Same with branch_not=1 -> 0x104; branch_not=1, zero=0 -> 0xFC.
//  T5 jumps: pc=0x1000_0000, instr=0x0C00_0040 (jal), jump=1 -> pc_plus4=0x1000_0004 until retire, next pc 0x1000_0100. jump=1 and jump_reg=1 with jr_target=0x2000 -> 0x2000.
//  T6 misaligned: jump_reg=1, jr_target=0x2002. With FETCH_MISALIGN_TRAP_EN -> fault=1, pc unchanged, imem_req=0 until reset. Without it -> next pc 0x2000, fault=0.

Source files
------------

// File: rtl/fetch_unit.sv
//============================================================================
// Module  : fetch_unit
// Brief   : MIPS fetch stage: PC, req/ready imem fetch, next-PC select.
//           Optional macro FETCH_MISALIGN_TRAP_EN halts on misaligned next PC.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   input  logic        retire,
   input  logic        branch,
   input  logic        branch_not,
   input  logic        zero,
   input  logic        jump,
   input  logic        jump_reg,
   input  logic [31:0] branch_imm,
   input  logic [31:0] jr_target,
   output logic        fault
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_HOLD  = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   state_t      state_q;
   logic [31:0] pc_q;
   logic [31:0] instr_q;
   logic        instr_valid_q;
   logic [31:0] next_pc_d;
   logic [31:0] pc_d;
   logic        taken;

   assign pc          = pc_q;
   assign pc_plus4    = pc_q + 32'd4;
   assign imem_addr   = pc_q;
   assign imem_req    = (state_q == S_FETCH);
   assign instr       = instr_q;
   assign instr_valid = instr_valid_q;

   // beq takes on zero, bne takes on not-zero
   assign taken = branch & (zero ^ branch_not);

   always_comb begin
      next_pc_d = pc_plus4;
      if (jump_reg) begin
         next_pc_d = jr_target;
      end else if (jump) begin
         next_pc_d = {pc_plus4[31:28], instr_q[25:0], 2'b00};
      end else if (taken) begin
         next_pc_d = pc_plus4 + (branch_imm << 2);
      end
   end

`ifdef FETCH_MISALIGN_TRAP_EN
   logic fault_q;
   logic misalign;

   assign misalign = |next_pc_d[1:0];
   assign pc_d     = next_pc_d;
   assign fault    = fault_q;
`else
   assign pc_d  = next_pc_d & 32'hFFFF_FFFC;
   assign fault = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         pc_q          <= RESET_PC;
         instr_q       <= '0;
         instr_valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
         fault_q       <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               state_q <= S_FETCH;
            end
            S_FETCH: begin
               if (imem_ready) begin
                  instr_q       <= imem_rdata;
                  instr_valid_q <= 1'b1;
                  state_q       <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (retire) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                  if (misalign) begin
                     // HALT keeps every output frozen until reset
                     fault_q <= 1'b1;
                     state_q <= S_HALT;
                  end else begin
                     pc_q          <= pc_d;
                     instr_valid_q <= 1'b0;
                     state_q       <= S_FETCH;
                  end
`else
                  pc_q          <= pc_d;
                  instr_valid_q <= 1'b0;
                  state_q       <= S_FETCH;
`endif
               end
            end
            default: begin
               state_q <= state_q;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
//============================================================================
// Module  : tb_fetch_unit
// Brief   : Scoreboard bench for fetch_unit with directed fetch sequences.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module tb_fetch_unit;

   localparam logic [31:0] C_RESET_PC = 32'h0040_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic [31:0] instr;
   logic        instr_valid;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        retire = 1'b0;
   logic        branch = 1'b0;
   logic        branch_not = 1'b0;
   logic        zero = 1'b0;
   logic        jump = 1'b0;
   logic        jump_reg = 1'b0;
   logic [31:0] branch_imm = '0;
   logic [31:0] jr_target = '0;
   logic        fault;

   fetch_unit #(.RESET_PC(C_RESET_PC)) dut (
      .clk        (clk),
      .reset      (reset),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ready (imem_ready),
      .imem_rdata (imem_rdata),
      .instr      (instr),
      .instr_valid(instr_valid),
      .pc         (pc),
      .pc_plus4   (pc_plus4),
      .retire     (retire),
      .branch     (branch),
      .branch_not (branch_not),
      .zero       (zero),
      .jump       (jump),
      .jump_reg   (jump_reg),
      .branch_imm (branch_imm),
      .jr_target  (jr_target),
      .fault      (fault)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] pc4;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   logic prev_v = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h want %08h", name, act, exp);
      end
   endtask

   // Monitor: every newly presented instruction is matched against the queue
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         prev_v = 1'b0;
      end else begin
         if (instr_valid && !prev_v) begin
            if (sb_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL sb_unexpected: got pc %08h want no instruction", pc);
            end else begin
               e = sb_q.pop_front();
               chk("mon_pc", pc, e.pc);
               chk("mon_instr", instr, e.instr);
               chk("mon_pc_plus4", pc_plus4, e.pc4);
            end
         end
         prev_v = instr_valid;
      end
   end

   task automatic wait_req(output int gap);
      gap = 0;
      do begin
         @(negedge clk);
         gap++;
      end while (!imem_req && gap < 20);
      if (!imem_req) begin
         n_cmp++;
         n_bad++;
         $display("FAIL req_timeout: got imem_req 0 want 1 within 20 cycles");
      end
   endtask

   // ctl = {jump_reg, jump, branch, branch_not, zero}
   task automatic step(input logic [31:0] epc, input logic [31:0] word, input int waits,
                       input logic rtr_early, input int hold, input int exp_gap,
                       input logic [4:0] ctl, input logic [31:0] imm, input logic [31:0] jrt);
      int gap;
      wait_req(gap);
      if (exp_gap > 0) chk("fetch_gap", 32'(gap), 32'(exp_gap));
      chk("imem_addr", imem_addr, epc);
      sb_q.push_back({epc, word, epc + 32'd4});
      for (int i = 0; i < waits; i++) begin
         imem_ready = 1'b0;
         retire     = rtr_early;
         @(negedge clk);
         chk("wait_req", {31'b0, imem_req}, 32'd1);
         chk("wait_addr", imem_addr, epc);
         chk("wait_valid", {31'b0, instr_valid}, 32'd0);
      end
      retire     = 1'b0;
      imem_ready = 1'b1;
      imem_rdata = word;
      @(posedge clk);
      #1;
      imem_rdata = 32'hDEAD_BEEF;
      repeat (hold) @(negedge clk);
      @(negedge clk);
      chk("hold_instr", instr, word);
      chk("hold_pc", pc, epc);
      chk("hold_pc_plus4", pc_plus4, epc + 32'd4);
      chk("hold_req", {31'b0, imem_req}, 32'd0);
      {jump_reg, jump, branch, branch_not, zero} = ctl;
      branch_imm = imm;
      jr_target  = jrt;
      retire     = 1'b1;
      @(posedge clk);
      #1;
      retire     = 1'b0;
      imem_ready = 1'b0;
      {jump_reg, jump, branch, branch_not, zero} = 5'b0;
      branch_imm = '0;
      jr_target  = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pc", pc, C_RESET_PC);
      chk("rst_req", {31'b0, imem_req}, 32'd0);
      chk("rst_valid", {31'b0, instr_valid}, 32'd0);
      chk("rst_instr", instr, 32'd0);
      chk("rst_fault", {31'b0, fault}, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("idle_req", {31'b0, imem_req}, 32'd0);
      @(negedge clk);
      chk("first_req", {31'b0, imem_req}, 32'd1);
      chk("first_addr", imem_addr, C_RESET_PC);
   endtask

   initial begin
      int gap;
      do_reset();

      // sequential zero-wait stream, then wait states with stray retire
      step(32'h0040_0000, 32'h2402_0001, 0, 1'b0, 0, 0, 5'b00000, '0, '0);
      step(32'h0040_0004, 32'h2402_0002, 0, 1'b0, 0, 1, 5'b00000, '0, '0);
      step(32'h0040_0008, 32'h2402_0003, 3, 1'b1, 1, 1, 5'b10000, '0, 32'h0000_0100);
      // branches around pc 0x100
      step(32'h0000_0100, 32'h1000_FFFE, 0, 1'b0, 0, 1, 5'b00101, 32'hFFFF_FFFE, '0);
      step(32'h0000_00FC, 32'h0000_0008, 0, 1'b0, 0, 1, 5'b10101, 32'hFFFF_FFFE, 32'h0000_0100);
      step(32'h0000_0100, 32'h1400_FFFE, 0, 1'b0, 0, 1, 5'b00111, 32'hFFFF_FFFE, '0);
      step(32'h0000_0104, 32'h0000_0008, 0, 1'b0, 0, 1, 5'b10000, '0, 32'h0000_0100);
      step(32'h0000_0100, 32'h1400_FFFE, 0, 1'b0, 0, 1, 5'b00110, 32'hFFFF_FFFE, '0);
      step(32'h0000_00FC, 32'h0000_0008, 0, 1'b0, 0, 1, 5'b10000, '0, 32'h1000_0000);
      // jal, then jump_reg overriding jump
      step(32'h1000_0000, 32'h0C00_0040, 0, 1'b0, 3, 1, 5'b01000, '0, '0);
      step(32'h1000_0100, 32'h0C00_0777, 0, 1'b0, 0, 1, 5'b11000, '0, 32'h0000_2000);
      // misaligned jr target
      step(32'h0000_2000, 32'h0000_0008, 0, 1'b0, 0, 1, 5'b10000, '0, 32'h0000_2002);
`ifdef FETCH_MISALIGN_TRAP_EN
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("halt_fault", {31'b0, fault}, 32'd1);
         chk("halt_pc", pc, 32'h0000_2000);
         chk("halt_req", {31'b0, imem_req}, 32'd0);
      end
`else
      step(32'h0000_2000, 32'h0000_0008, 0, 1'b0, 0, 1, 5'b10000, '0, 32'hFFFF_FFFC);
      chk("no_fault", {31'b0, fault}, 32'd0);
      step(32'hFFFF_FFFC, 32'h0000_0000, 0, 1'b0, 0, 1, 5'b00000, '0, '0);
      // reset in the middle of a wait-stated fetch at address 0
      wait_req(gap);
      chk("wrap_addr", imem_addr, 32'h0000_0000);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_req", {31'b0, imem_req}, 32'd0);
      chk("abort_pc", pc, C_RESET_PC);
`endif
      do_reset();
      step(C_RESET_PC, 32'h2402_0009, 0, 1'b0, 0, 0, 5'b00000, '0, '0);
      repeat (2) @(negedge clk);
      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #50000;
      n_cmp++;
      n_bad++;
      $display("FAIL watchdog: got no completion want finish before 50000ns");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
